// File: rtl/motor_pkg.sv
// motor_pkg: shared FSM states, direction constants and saturation helpers for the motor driver.
package motor_pkg;
    typedef enum logic {DRIVE = 1'b0, DEAD = 1'b1} state_t;
    localparam logic FWD = 1'b1;
    localparam logic REV = 1'b0;
    function automatic int sat(input int v, input int maxmag);
        return v < -maxmag ? -maxmag : (v > maxmag ? maxmag : v);
    endfunction
    function automatic int abs(input int v);
        return v < 0 ? -v : v;
    endfunction
endpackage

// File: rtl/multi_motor_driver_if.sv
// multi_motor_driver_if: velocity command inputs and H-bridge outputs of the multi-channel driver.
interface multi_motor_driver_if #(
    parameter int NUM_CH = 2,
    parameter int VEL_W = 8
);
    logic [NUM_CH*VEL_W-1:0] velocity;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] ena;
    logic [NUM_CH-1:0] dir;
    logic [NUM_CH*VEL_W-1:0] vel_actual;
    logic [NUM_CH-1:0] reversing;
    logic period_start;
    modport master (output velocity, enable, input ena, dir, vel_actual, reversing, period_start);
    modport slave (input velocity, enable, output ena, dir, vel_actual, reversing, period_start);
endinterface

// File: rtl/motor_channel.sv
// motor_channel: one H-bridge channel with slew-limited ramp, dead-time reversal FSM and PWM compare.
module motor_channel
    import motor_pkg::*;
#(
    parameter int VEL_W = 8,
    parameter int SLEW_STEP = 16,
    parameter int DEADTIME = 2
) (
    input  logic cclk,
    input  logic rstb,
    input  logic [VEL_W-2:0] cnt,
    input  logic boundary,
    input  logic signed [VEL_W-1:0] target,
    output logic ena,
    output logic dir,
    output logic reversing,
    output logic signed [VEL_W-1:0] actual
);
    localparam int MAXMAG = 2**(VEL_W-1) - 1;
    localparam int DW = DEADTIME > 0 ? $clog2(DEADTIME + 1) : 1;
    localparam logic signed [VEL_W:0] MM = (VEL_W+1)'(MAXMAG);
    localparam logic signed [VEL_W:0] SL = (VEL_W+1)'(SLEW_STEP > 2*MAXMAG ? 2*MAXMAG : SLEW_STEP);
    state_t state;
    logic [DW-1:0] dcnt;
    logic signed [VEL_W:0] a_x, t_x, to_t, to_z;
    logic [VEL_W-2:0] mag;
    logic opp;

    function automatic logic signed [VEL_W:0] step_to(input logic signed [VEL_W:0] a, input logic signed [VEL_W:0] t);
        logic signed [VEL_W:0] d, s, r;
        d = t - a;
        s = d > SL ? SL : (d < -SL ? -SL : d);
        r = a + s;
        return r > MM ? MM : (r < -MM ? -MM : r);
    endfunction

    assign a_x = {actual[VEL_W-1], actual};
    assign t_x = {target[VEL_W-1], target};
    assign to_t = step_to(a_x, t_x);
    assign to_z = step_to(a_x, '0);
    assign mag = (VEL_W-1)'(abs(int'(actual)));
    // a nonzero target opposes dir when its sign bit equals dir (FWD=1 vs negative)
    assign opp = (target != '0) && (target[VEL_W-1] == dir);

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state <= DRIVE;
            dcnt <= '0;
            actual <= '0;
            dir <= FWD;
            reversing <= 1'b0;
            ena <= 1'b0;
        end else begin
            ena <= (state == DRIVE) && (mag > cnt);
            if (boundary) begin
                if (!opp) begin
                    state <= DRIVE;
                    reversing <= 1'b0;
                    actual <= VEL_W'(to_t);
                end else if (state == DRIVE && actual != '0) begin
                    actual <= VEL_W'(to_z);
                end else if (state == DRIVE && DEADTIME != 0) begin
                    state <= DEAD;
                    reversing <= 1'b1;
                    dcnt <= DW'(DEADTIME);
                end else if (state == DEAD && dcnt > DW'(1)) begin
                    dcnt <= dcnt - 1'b1;
                end else begin
                    dir <= dir == FWD ? REV : FWD;
                    actual <= VEL_W'(to_t);
                    state <= DRIVE;
                    reversing <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/multi_motor_driver.sv
// multi_motor_driver: N-channel H-bridge driver sharing one prescaled PWM timebase.
module multi_motor_driver
    import motor_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int VEL_W = 8,
    parameter int PRESCALE = 1,
    parameter int SLEW_STEP = 16,
    parameter int DEADTIME = 2
) (
    input logic cclk,
    input logic rstb,
    multi_motor_driver_if.slave bus
);
    localparam int MAXMAG = 2**(VEL_W-1) - 1;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pcnt;
    logic [VEL_W-2:0] cnt;
    logic tick, boundary, ps;
    logic [NUM_CH-1:0] ena_v, dir_v, rev_v;
    logic [NUM_CH*VEL_W-1:0] act_v;

    assign tick = pcnt == PW'(PRESCALE - 1);
    assign boundary = tick && cnt == (VEL_W-1)'(MAXMAG - 1);

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            pcnt <= '0;
            cnt <= '0;
            ps <= 1'b0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) cnt <= boundary ? '0 : cnt + 1'b1;
            ps <= boundary;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic signed [VEL_W-1:0] v, t, a;
        logic e, d, r;
        assign v = bus.velocity[i*VEL_W +: VEL_W];
        assign t = bus.enable[i] ? VEL_W'(sat(int'(v), MAXMAG)) : '0;
        motor_channel #(.VEL_W(VEL_W), .SLEW_STEP(SLEW_STEP), .DEADTIME(DEADTIME)) u_ch (
            .cclk(cclk), .rstb(rstb), .cnt(cnt), .boundary(boundary), .target(t),
            .ena(e), .dir(d), .reversing(r), .actual(a)
        );
        assign ena_v[i] = e;
        assign dir_v[i] = d;
        assign rev_v[i] = r;
        assign act_v[i*VEL_W +: VEL_W] = a;
    end

    assign bus.ena = ena_v;
    assign bus.dir = dir_v;
    assign bus.reversing = rev_v;
    assign bus.vel_actual = act_v;
    assign bus.period_start = ps;
endmodule

// File: tb/tb_multi_motor_driver.sv
// tb_multi_motor_driver: scoreboard bench; per-period expectations are queued by the stimulus and popped at period_start.
module tb_multi_motor_driver;
    logic cclk = 1'b0;
    logic rstb = 1'b0;
    always #5 cclk = ~cclk;

    multi_motor_driver_if #(.NUM_CH(2), .VEL_W(8)) bus ();
    multi_motor_driver_if #(.NUM_CH(2), .VEL_W(8)) bus0 ();
    multi_motor_driver #(.NUM_CH(2), .VEL_W(8), .PRESCALE(1), .SLEW_STEP(16), .DEADTIME(2)) dut (
        .cclk(cclk), .rstb(rstb), .bus(bus));
    multi_motor_driver #(.NUM_CH(2), .VEL_W(8), .PRESCALE(1), .SLEW_STEP(16), .DEADTIME(0)) dut0 (
        .cclk(cclk), .rstb(rstb), .bus(bus0));

    // channels 0,1 of the DEADTIME=2 build and channel 0 of the DEADTIME=0 build
    typedef struct packed {
        logic [2:0][7:0] a;
        logic [2:0] d;
        logic [2:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t e, ep1, ep2;
    int errors = 0, checks = 0, npop = 0, cyc = 0;
    int hi[3];
    logic mon_on = 1'b0;
    logic [2:0] ena_all, dir_all, rev_all;
    logic [2:0][7:0] act_all;
    assign ena_all = {bus0.ena[0], bus.ena};
    assign dir_all = {bus0.dir[0], bus.dir};
    assign rev_all = {bus0.reversing[0], bus.reversing};
    assign act_all = {bus0.vel_actual[7:0], bus.vel_actual};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int a0, d0, r0, a1, d1, r1, ab, db, rb);
        exp_t x;
        x.a[0] = 8'(a0); x.d[0] = d0[0]; x.r[0] = r0[0];
        x.a[1] = 8'(a1); x.d[1] = d1[0]; x.r[1] = r1[0];
        x.a[2] = 8'(ab); x.d[2] = db[0]; x.r[2] = rb[0];
        return x;
    endfunction

    // ena high-cycle count over one period: last compare of the old period plus the new magnitude
    function automatic int duty(input exp_t o, input exp_t n, input int k);
        int ao, an;
        ao = int'($signed(o.a[k]));
        an = int'($signed(n.a[k]));
        ao = ao < 0 ? -ao : ao;
        an = an < 0 ? -an : an;
        return ((!o.r[k] && ao == 127) ? 1 : 0) + (!n.r[k] ? (an > 126 ? 126 : an) : 0);
    endfunction

    always @(negedge cclk) begin
        if (mon_on) begin
            if (bus.period_start) begin
                if (npop > 0) check("period_len", cyc, 127);
                if (npop > 1)
                    for (int k = 0; k < 3; k++) check($sformatf("duty%0d", k), hi[k], duty(ep2, ep1, k));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got 0 entries expected 1");
                end else begin
                    e = sb.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        check($sformatf("p%0d_act%0d", npop + 1, k), int'($signed(act_all[k])), int'($signed(e.a[k])));
                        check($sformatf("p%0d_dir%0d", npop + 1, k), int'(dir_all[k]), int'(e.d[k]));
                        check($sformatf("p%0d_rev%0d", npop + 1, k), int'(rev_all[k]), int'(e.r[k]));
                    end
                    ep2 = ep1;
                    ep1 = e;
                end
                npop++;
                cyc = 1;
                for (int k = 0; k < 3; k++) hi[k] = int'(ena_all[k]);
            end else begin
                cyc++;
                for (int k = 0; k < 3; k++) hi[k] += int'(ena_all[k]);
            end
        end
    end

    task automatic step(input int v0, v1, vb, input logic [1:0] en, input exp_t x);
        logic seen;
        bus.velocity = {8'(v1), 8'(v0)};
        bus.enable = en;
        bus0.velocity = {8'd0, 8'(vb)};
        bus0.enable = 2'b11;
        sb.push_back(x);
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge cclk);
            seen = bus.period_start;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no period_start expected one within 300 cycles");
        end
    endtask

    initial begin
        ep1 = mk(0, 1, 0, 0, 1, 0, 0, 1, 0);
        ep2 = ep1;
        bus.velocity = '0;
        bus.enable = '0;
        bus0.velocity = '0;
        bus0.enable = '0;
        #23 rstb = 1'b1;
        bus.enable = 2'b11;
        bus.velocity = {8'(-127), 8'd127};
        repeat (640) @(negedge cclk);
        #3 rstb = 1'b0;
        #1;
        check("rst_ena", int'(bus.ena), 0);
        check("rst_dir", int'(bus.dir), 3);
        check("rst_act", int'(bus.vel_actual), 0);
        check("rst_rev", int'(bus.reversing), 0);
        check("rst_ps", int'(bus.period_start), 0);
        check("rst_dir_dt0", int'(bus0.dir), 3);
        bus.velocity = '0;
        @(negedge cclk);
        rstb = 1'b1;
        mon_on = 1'b1;
        step(0, 0, 0, 2'b11, mk(0, 1, 0, 0, 1, 0, 0, 1, 0));
        step(0, 0, 0, 2'b11, mk(0, 1, 0, 0, 1, 0, 0, 1, 0));
        step(64, 0, 16, 2'b11, mk(16, 1, 0, 0, 1, 0, 16, 1, 0));
        step(64, 0, 16, 2'b11, mk(32, 1, 0, 0, 1, 0, 16, 1, 0));
        step(64, 0, -16, 2'b11, mk(48, 1, 0, 0, 1, 0, 0, 1, 0));
        step(64, 0, -16, 2'b11, mk(64, 1, 0, 0, 1, 0, -16, 0, 0));
        step(64, 0, -16, 2'b11, mk(64, 1, 0, 0, 1, 0, -16, 0, 0));
        step(64, 0, 0, 2'b11, mk(64, 1, 0, 0, 1, 0, 0, 0, 0));
        step(-32, 0, 32, 2'b11, mk(48, 1, 0, 0, 1, 0, 16, 1, 0));
        step(-32, 0, 32, 2'b11, mk(32, 1, 0, 0, 1, 0, 32, 1, 0));
        step(-32, 0, 32, 2'b11, mk(16, 1, 0, 0, 1, 0, 32, 1, 0));
        step(-32, 0, 32, 2'b11, mk(0, 1, 0, 0, 1, 0, 32, 1, 0));
        step(-32, 0, 32, 2'b11, mk(0, 1, 1, 0, 1, 0, 32, 1, 0));
        step(-32, 0, 32, 2'b11, mk(0, 1, 1, 0, 1, 0, 32, 1, 0));
        step(-32, 0, 32, 2'b11, mk(-16, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-32, 0, 32, 2'b11, mk(-32, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-32, 0, 32, 2'b11, mk(-32, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, 0, 32, 2'b11, mk(-48, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, 0, 32, 2'b11, mk(-64, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, 0, 32, 2'b11, mk(-80, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, 0, 32, 2'b11, mk(-96, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, 0, 32, 2'b11, mk(-112, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, 0, 32, 2'b11, mk(-127, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, 0, 32, 2'b11, mk(-127, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, 0, 32, 2'b11, mk(-127, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, -50, 32, 2'b11, mk(-127, 0, 0, 0, 1, 1, 32, 1, 0));
        step(-128, 40, 32, 2'b11, mk(-127, 0, 0, 16, 1, 0, 32, 1, 0));
        step(-128, 40, 32, 2'b11, mk(-127, 0, 0, 32, 1, 0, 32, 1, 0));
        step(-128, 40, 32, 2'b11, mk(-127, 0, 0, 40, 1, 0, 32, 1, 0));
        step(-128, 40, 32, 2'b11, mk(-127, 0, 0, 40, 1, 0, 32, 1, 0));
        step(-128, -100, 32, 2'b01, mk(-127, 0, 0, 24, 1, 0, 32, 1, 0));
        step(-128, -100, 32, 2'b01, mk(-127, 0, 0, 8, 1, 0, 32, 1, 0));
        step(-128, -100, 32, 2'b01, mk(-127, 0, 0, 0, 1, 0, 32, 1, 0));
        step(-128, -100, 32, 2'b01, mk(-127, 0, 0, 0, 1, 0, 32, 1, 0));
        @(negedge cclk);
        mon_on = 1'b0;
        check("sb_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
